present_dec_otf: RTL and testbench
==================================

Name: present_dec_otf

Overview:
Iterative PRESENT-80 decryption core that generates its round keys on the fly by running the key schedule in reverse, so it needs no round-key memory.
- A forward pass over the 80-bit key register produces the final key state K32.
- Each decryption round then undoes one key-schedule step, yielding K31 down to K1.
- The block is the decrypt-side counterpart to the memory-based key schedule and sits beside the encryption datapath in the cipher subsystem.
- An optional cache skips the forward pass when the key is unchanged.

Parameters:
CACHE_KEY, 1, 1 = keep the K32 key state and the key it came from; skip KEY_FWD when the same key is presented again. 0 = always run KEY_FWD.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a clk edge resets)
key  input  80  master key, sampled with start
start  input  1  request; accepted only in IDLE
block_i  input  64  ciphertext, sampled with start
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse, block_o valid
block_o  output  64  plaintext; holds until the next done

Behaviour:
- Reset (rst==0): state IDLE, busy=0, done=0, block_o=0, round counter=0, cache valid flag=0. Reset mid-operation aborts immediately and leaves no partial result on block_o.
- Forward key step with round counter r (1..31), applied to the 80-bit register K:
  - K = K rotated left by 61;
  - K[79:76] = S(K[79:76]);
  - K[19:15] ^= r.
- Inverse key step with r:
  - K[19:15] ^= r;
  - K[79:76] = S^-1(K[79:76]);
  - K = K rotated right by 61.
- Round key = K[79:16].
- S-box S = C56B90AD3EF84712 (hex, indexed by input 0..F). S^-1 is its inverse.
- pLayer P: bit i moves to bit 16*i mod 63 for i<63; bit 63 stays. P^-1 is its inverse.
- FSM states:
  - IDLE:
    - On start, latch block_i into state register S and key into K, clear the counter, set busy.
    - If CACHE_KEY=1, cache valid and key equals the cached key: load K from the K32 cache and go to WHITEN.
    - Otherwise go to KEY_FWD with r=1.
  - KEY_FWD: one forward step per cycle, r=1..31. After r=31, K holds K32; write the cache (K32, key, valid=1) and go to WHITEN.
  - WHITEN: S ^= K[79:16]; set r=31; go to ROUND.
  - ROUND: one cycle per round, r=31 down to 1.
    - Knew = inverse_step(K, r);
    - S = S^-1(P^-1(S)) ^ Knew[79:16], with S^-1 applied to all 16 nibbles;
    - K = Knew;
    - r decrements. After r=1, K equals the master key again and S holds the plaintext; go to DONE.
  - DONE: block_o = S, done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency, counted from the edge that samples start:
  - done is high on cycle 64 without a cache hit (31+1+31+1).
  - done is high on cycle 33 with a cache hit.
- start while busy or in DONE is ignored, not queued.
- A new start may be sampled in the IDLE cycle that follows DONE.
- key and block_i may change after acceptance without effect.
- Counter width is 5 bits; the XOR uses the full 5-bit r. r never wraps: 0 and 32 are not used as round indices.
- Cache comparison is the full 80-bit key.
- Reset invalidates the cache.

Test Plan:
- Reset: rst=0 for 2 cycles while start=1 -> busy=0, done=0, block_o=0, no acceptance until rst=1.
- key=0, block_i=5579C1387B228445 -> block_o=0000000000000000, done at cycle 64.
- key=FFFFFFFFFFFFFFFFFFFF, block_i=3333DCD3213210D2 -> block_o=FFFFFFFFFFFFFFFF.
  - Repeat with the same key and block_i=E72C46C0F5945049 -> block_o=0000000000000000, done at cycle 33 (CACHE_KEY=1) or 64 (CACHE_KEY=0).
- key=0, block_i=A112FFC72F68417B -> block_o=FFFFFFFFFFFFFFFF.
  - Pulse start again at cycle 10 with different data -> ignored; result unchanged, done only once.
- Assert rst=0 at cycle 40 of a job, then start key=0, block_i=5579C1387B228445 -> full 64-cycle latency (cache invalidated), block_o=0.

Source files
------------

// File: rtl/present_dec_otf.sv
`default_nettype none
// ============================================================================
// Module   : present_dec_otf
// Brief    : Iterative PRESENT-80 decryptor with on-the-fly reverse key schedule
//            and an optional K32 key-state cache.
// Revision : 1.0 - initial release
// ============================================================================
module present_dec_otf #(
    parameter int CACHE_KEY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] key,
    input  logic        start,
    input  logic [63:0] block_i,
    output logic        busy,
    output logic        done,
    output logic [63:0] block_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEY_FWD = 3'd1,
        ST_WHITEN  = 3'd2,
        ST_ROUND   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [4:0] c_last_round = 5'd31;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl  = 64'hC56B90AD3EF84712;
        sbox = tbl[4*(15 - x) +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [63:0] tbl;
        tbl      = 64'h5EF8C12DB463079A;
        sbox_inv = tbl[4*(15 - x) +: 4];
    endfunction

    function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ r;
        fwd_step   = t;
    endfunction

    function automatic logic [79:0] inv_step(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ r;
        t[79:76]   = sbox_inv(t[79:76]);
        inv_step   = {t[60:0], t[79:61]};
    endfunction

    // Inverse permutation followed by the inverse S-box on every nibble.
    function automatic logic [63:0] inv_layers(input logic [63:0] x);
        logic [63:0] p;
        for (int i = 0; i < 63; i++) begin
            p[i] = x[(16 * i) % 63];
        end
        p[63] = x[63];
        for (int n = 0; n < 16; n++) begin
            inv_layers[4*n +: 4] = sbox_inv(p[4*n +: 4]);
        end
    endfunction

    state_t      r_state,       w_state_nxt;
    logic [79:0] r_k,           w_k_nxt;
    logic [63:0] r_s,           w_s_nxt;
    logic [4:0]  r_r,           w_r_nxt;
    logic        r_busy,        w_busy_nxt;
    logic        r_done,        w_done_nxt;
    logic [63:0] r_block_o,     w_block_o_nxt;
    logic [79:0] r_cache_k32,   w_cache_k32_nxt;
    logic [79:0] r_cache_key,   w_cache_key_nxt;
    logic        r_cache_valid, w_cache_valid_nxt;
    logic [79:0] r_key_lat,     w_key_lat_nxt;

    logic        w_hit;
    logic [79:0] w_k_fwd;
    logic [79:0] w_k_inv;

    assign w_hit   = (CACHE_KEY != 0) && r_cache_valid && (key == r_cache_key);
    assign w_k_fwd = fwd_step(r_k, r_r);
    assign w_k_inv = inv_step(r_k, r_r);

    always_comb begin
        w_state_nxt       = r_state;
        w_k_nxt           = r_k;
        w_s_nxt           = r_s;
        w_r_nxt           = r_r;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_block_o_nxt     = r_block_o;
        w_cache_k32_nxt   = r_cache_k32;
        w_cache_key_nxt   = r_cache_key;
        w_cache_valid_nxt = r_cache_valid;
        w_key_lat_nxt     = r_key_lat;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_s_nxt       = block_i;
                    w_key_lat_nxt = key;
                    w_busy_nxt    = 1'b1;
                    if (w_hit) begin
                        w_k_nxt     = r_cache_k32;
                        w_r_nxt     = 5'd0;
                        w_state_nxt = ST_WHITEN;
                    end else begin
                        w_k_nxt     = key;
                        w_r_nxt     = 5'd1;
                        w_state_nxt = ST_KEY_FWD;
                    end
                end
            end
            ST_KEY_FWD: begin
                w_k_nxt = w_k_fwd;
                if (r_r == c_last_round) begin
                    w_cache_k32_nxt   = w_k_fwd;
                    w_cache_key_nxt   = r_key_lat;
                    w_cache_valid_nxt = 1'b1;
                    w_state_nxt       = ST_WHITEN;
                end else begin
                    w_r_nxt = r_r + 5'd1;
                end
            end
            ST_WHITEN: begin
                w_s_nxt     = r_s ^ r_k[79:16];
                w_r_nxt     = c_last_round;
                w_state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                w_s_nxt = inv_layers(r_s) ^ w_k_inv[79:16];
                w_k_nxt = w_k_inv;
                if (r_r == 5'd1) begin
                    w_r_nxt     = 5'd0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_r_nxt = r_r - 5'd1;
                end
            end
            ST_DONE: begin
                w_block_o_nxt = r_s;
                w_done_nxt    = 1'b1;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_k           <= '0;
            r_s           <= '0;
            r_r           <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_block_o     <= '0;
            r_cache_k32   <= '0;
            r_cache_key   <= '0;
            r_cache_valid <= 1'b0;
            r_key_lat     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_k           <= w_k_nxt;
            r_s           <= w_s_nxt;
            r_r           <= w_r_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_block_o     <= w_block_o_nxt;
            r_cache_k32   <= w_cache_k32_nxt;
            r_cache_key   <= w_cache_key_nxt;
            r_cache_valid <= w_cache_valid_nxt;
            r_key_lat     <= w_key_lat_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign block_o = r_block_o;

endmodule
`default_nettype wire

// File: tb/tb_present_dec_otf.sv
`default_nettype none
// ============================================================================
// Module   : tb_present_dec_otf
// Brief    : Scoreboard bench for present_dec_otf using PRESENT-80 vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_present_dec_otf;

    localparam int CACHE = 1;
    localparam int LAT_MISS = 64;
    localparam int LAT_HIT  = (CACHE != 0) ? 33 : 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [79:0] key = '0;
    logic        start = 1'b0;
    logic [63:0] block_i = '0;
    logic        busy;
    logic        done;
    logic [63:0] block_o;

    present_dec_otf #(.CACHE_KEY(CACHE)) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .start   (start),
        .block_i (block_i),
        .busy    (busy),
        .done    (done),
        .block_o (block_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] expv;
        int          t0;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic checkint(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL unexpected_done: got done with block_o=%h want no done", block_o);
            end else begin
                e = sb.pop_front();
                check64({e.name, "_data"}, block_o, e.expv);
                checkint({e.name, "_latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input logic [79:0] k, input logic [63:0] b, input logic [63:0] expv,
                         input int lat, input string nm, input bit push);
        exp_t e;
        @(negedge clk);
        key     = k;
        block_i = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        key     = ~k;
        block_i = ~b;
        checkint({nm, "_busy"}, int'(busy), 1);
        e.expv = expv;
        e.t0   = cyc;
        e.lat  = lat;
        e.name = nm;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checkint({nm, "_outstanding"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with start asserted: nothing may be accepted.
        rst     = 1'b0;
        start   = 1'b1;
        key     = '0;
        block_i = 64'h5579C1387B228445;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkint("rst_busy", int'(busy), 0);
            checkint("rst_done", int'(done), 0);
            check64("rst_block_o", block_o, 64'h0);
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkint("post_rst_busy", int'(busy), 0);

        issue(80'h0, 64'h5579C1387B228445, 64'h0000000000000000, LAT_MISS, "k0_pt0", 1'b1);
        wait_drain("k0_pt0");

        issue({80{1'b1}}, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, LAT_MISS, "kF_ptF", 1'b1);
        wait_drain("kF_ptF");
        check64("hold_block_o", block_o, 64'hFFFFFFFFFFFFFFFF);

        issue({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0000000000000000, LAT_HIT, "kF_pt0_cached", 1'b1);
        wait_drain("kF_pt0_cached");

        // A start pulse ten cycles into a job must be dropped.
        issue(80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, LAT_MISS, "k0_ptF", 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        key     = 80'h0123456789ABCDEF0123;
        block_i = 64'h5579C1387B228445;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        checkint("ignored_start_busy", int'(busy), 1);
        wait_drain("k0_ptF");
        repeat (80) @(posedge clk);
        #1;
        check64("ignored_start_block_o", block_o, 64'hFFFFFFFFFFFFFFFF);

        // Abort a cache-miss job at cycle 40 with reset.
        issue({80{1'b1}}, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, LAT_MISS, "aborted", 1'b0);
        repeat (39) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check64("abort_block_o", block_o, 64'h0);
        checkint("abort_busy", int'(busy), 0);
        checkint("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;

        issue(80'h0, 64'h5579C1387B228445, 64'h0000000000000000, LAT_MISS, "k0_after_rst", 1'b1);
        wait_drain("k0_after_rst");
        repeat (5) @(posedge clk);
        #1;
        checkint("final_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
